pio_access_arbiter: RTL and testbench
=====================================

Name: pio_access_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 16-bit Avalon-MM PIO output slave (data register at address 0, bit-set at address 4, bit-clear at address 5).
- Lets the Nios II bridge (requester 0) and a hardware control engine (requester 1) share the PIO without read-modify-write races.
- Converts each request into exactly one PIO bus cycle and returns completion and read data.
- Sits between the requesters and the PIO slave port, in the same clock domain as the PIO.

Parameters:
DATA_W, 16, PIO data width; writedata is zero-extended to 32 bits.
ADDR_W, 3, PIO address width.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req0  in  1  requester 0 request level
op0  in  2  requester 0 op: 00 write, 01 set bits, 10 clear bits, 11 read
wdata0  in  DATA_W  requester 0 write/set/clear mask
done0  out  1  one-cycle completion pulse to requester 0
req1  in  1  requester 1 request level
op1  in  2  requester 1 op (same encoding as op0)
wdata1  in  DATA_W  requester 1 data/mask
done1  out  1  one-cycle completion pulse to requester 1
rdata  out  DATA_W  read result, valid while done0 or done1 is high, held until the next read completes
busy  out  1  high in any state other than IDLE
pio_address  out  ADDR_W  to PIO address
pio_chipselect  out  1  to PIO chipselect
pio_write_n  out  1  to PIO write_n, active low
pio_writedata  out  32  to PIO writedata
pio_readdata  in  32  from PIO readdata (combinational, zero wait states)

Behaviour:
- Clock is clk. Reset is reset_n, asynchronous, active-low.
- Reset values:
  - Outputs: done0/done1/busy/pio_chipselect = 0; pio_write_n = 1; pio_address, pio_writedata, rdata = 0.
  - Internal: state = IDLE; round-robin pointer last_grant = 1, so requester 0 wins the first tie.
- FSM states:
  - IDLE: sample req0/req1 at the clock edge.
    - No request: stay in IDLE.
    - One requester: grant it.
    - Both requesters: grant the one not equal to last_grant.
    - On a grant: register the winner's op and wdata, update last_grant, go to ISSUE.
  - ISSUE: exactly one cycle with pio_chipselect = 1.
    - pio_address = 0 for write/read, 4 for set, 5 for clear.
    - pio_write_n = 0 for write/set/clear, 1 for read.
    - pio_writedata = {16'b0, wdata}.
    - For a read, capture pio_readdata[DATA_W-1:0] into rdata at the end of the cycle.
    - Go to DONE.
  - DONE: pio_chipselect = 0, pio_write_n = 1; pulse done of the granted requester for one cycle; go to IDLE.
- Latency and throughput:
  - A request sampled at edge N gives ISSUE in cycle N+1 and done in cycle N+2.
  - Minimum spacing between PIO accesses is 3 cycles.
- Handshake rules:
  - A requester holds req, op and wdata stable from assertion until it sees done.
  - A requester deasserts req in the cycle after done. A req still high at the next IDLE sample is treated as a new request.
  - The non-granted requester keeps waiting; its request is never dropped.
- Fairness: with both requesters asserting continuously, grants alternate 0,1,0,1. The worst-case wait is one transaction (3 cycles).
- Only a DONE cycle can assert a done output, so done0 and done1 are never high together.
- op and wdata changes outside IDLE are ignored; the values registered at grant are used.
- Reset mid-transaction: the bus cycle is aborted immediately (chipselect drops asynchronously), no done pulse is issued, and the FSM returns to IDLE. The PIO contents are whatever the PIO's own reset yields.
- pio_address, pio_writedata and rdata hold their last values when idle; only chipselect qualifies them.

Optional Feature:
- Macro PIO_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Requester 0 always wins a simultaneous request, and last_grant is unused. Requester 1 can starve, which is acceptable for emergency-stop writes from the CPU.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Reset, then req0 with op0 = 00, wdata0 = 0x00A5 -> ISSUE cycle shows address 0, write_n 0, writedata 0x000000A5; done0 high for 1 cycle, 2 cycles after the sample edge; PIO out_port = 0x00A5.
- With PIO = 0x00A5: req1 set 0x0F00, then req1 clear 0x0005 -> PIO addresses 4 then 5; out_port ends at 0x0FA0; two done1 pulses.
- req0 read with PIO = 0x0FA0 -> pio_write_n stays 1; rdata = 0x0FA0 in the done0 cycle and held afterwards.
- req0 and req1 asserted continuously for 4 transactions from reset -> grant order 0,1,0,1; chipselect pulses 3 cycles apart; no overlapping done pulses. With PIO_ARB_FIXED_PRIO_EN defined -> order 0,0,0,0.
- reset_n asserted during ISSUE of a write 0x1234 -> chipselect drops immediately, no done pulse, busy = 0; after release, a new req0 completes normally.
- req0 held high one extra cycle after done0 -> a second identical bus cycle is issued, confirming the level-request rule.

Source files
------------

// File: rtl/pio_access_arbiter.sv
// Two-requester arbiter/sequencer in front of a 16-bit Avalon-MM PIO slave.
// Round-robin by default; define PIO_ARB_FIXED_PRIO_EN for fixed priority to requester 0.
module pio_access_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic [1:0]        op0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              done0,
    input  logic              req1,
    input  logic [1:0]        op1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] pio_address,
    output logic              pio_chipselect,
    output logic              pio_write_n,
    output logic [31:0]       pio_writedata,
    input  logic [31:0]       pio_readdata
);

    // Handshake: a requester holds req/op/wdata stable until its one-cycle done pulse
    // and drops req in the following cycle; a req still high at the next IDLE sample
    // is a new request. The losing requester simply keeps req high and is served next.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    state_t              state;
    state_t              state_nxt;
    logic                grant_valid;
    logic                grant_id;
    logic                grant_q;
    logic                is_read_q;
    logic [1:0]          sel_op;
    logic [DATA_W-1:0]   sel_wdata;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   wdata_q;
    logic                unused_readdata;

    assign unused_readdata = &{1'b0, pio_readdata[31:DATA_W]};

`ifdef PIO_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = ~req0;
    end
`else
    logic last_grant;

    // last_grant resets to 1 so requester 0 wins the first tie.
    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = (req0 && req1) ? ~last_grant : ~req0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (state == IDLE && grant_valid) begin
            last_grant <= grant_id;
        end
    end
`endif

    always_comb begin
        sel_op    = grant_id ? op1 : op0;
        sel_wdata = grant_id ? wdata1 : wdata0;
        case (sel_op)
            OP_SET:   sel_addr = ADDR_W'(4);
            OP_CLEAR: sel_addr = ADDR_W'(5);
            default:  sel_addr = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address and writedata are latched at grant so they hold while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q     <= 1'b0;
            is_read_q   <= 1'b0;
            pio_address <= '0;
            wdata_q     <= '0;
            rdata       <= '0;
        end else begin
            if (state == IDLE && grant_valid) begin
                grant_q     <= grant_id;
                is_read_q   <= (sel_op == OP_READ);
                pio_address <= sel_addr;
                wdata_q     <= sel_wdata;
            end
            if (state == ISSUE && is_read_q) begin
                rdata <= pio_readdata[DATA_W-1:0];
            end
        end
    end

    // Bus strobes decode straight from state so a reset drops them immediately.
    assign pio_chipselect = (state == ISSUE);
    assign pio_write_n    = !((state == ISSUE) && !is_read_q);
    assign pio_writedata  = {{(32-DATA_W){1'b0}}, wdata_q};
    assign done0          = (state == DONE) && !grant_q;
    assign done1          = (state == DONE) && grant_q;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_pio_access_arbiter.sv
// Self-checking bench for pio_access_arbiter with a behavioural PIO slave and
// a transaction-level arbitration model (honours PIO_ARB_FIXED_PRIO_EN).
module tb_pio_access_arbiter;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int EW     = 37;  // {who, addr[2:0], write_n, wdata[15:0], rdata[15:0]}

`ifdef PIO_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req0 = 1'b0, req1 = 1'b0;
    logic [1:0]        op0 = '0, op1 = '0;
    logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
    logic              done0, done1, busy;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] pio_address;
    logic              pio_chipselect, pio_write_n;
    logic [31:0]       pio_writedata, pio_readdata;

    logic [15:0]       pio_reg;
    logic [EW-1:0]     exp_q[$];
    int                checks = 0;
    int                errors = 0;

    pio_access_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .op0(op0), .wdata0(wdata0), .done0(done0),
        .req1(req1), .op1(op1), .wdata1(wdata1), .done1(done1),
        .rdata(rdata), .busy(busy),
        .pio_address(pio_address), .pio_chipselect(pio_chipselect),
        .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
        .pio_readdata(pio_readdata)
    );

    always #5 clk = ~clk;

    // Behavioural PIO output slave: data at 0, bit-set at 4, bit-clear at 5.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) pio_reg <= '0;
        else if (pio_chipselect && !pio_write_n) begin
            case (pio_address)
                3'd0: pio_reg <= pio_writedata[15:0];
                3'd4: pio_reg <= pio_reg | pio_writedata[15:0];
                3'd5: pio_reg <= pio_reg & ~pio_writedata[15:0];
                default: ;
            endcase
        end
    end
    assign pio_readdata = {16'h0, pio_reg};

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Drives one request from an idle arbiter; returns what the bus and handshake did.
    task automatic drive_txn(input bit who, input logic [1:0] op, input logic [15:0] data,
                             output int cs_n, output int cs_cyc, output int done_cyc,
                             output logic [2:0] a, output logic wn, output logic [31:0] wd,
                             output logic [15:0] rd, output bit other_done, output bit tail_bad);
        cs_n = 0; cs_cyc = -1; done_cyc = -1; a = 'x; wn = 'x; wd = 'x; rd = 'x;
        other_done = 1'b0;
        if (who) begin req1 = 1'b1; op1 = op; wdata1 = data; end
        else     begin req0 = 1'b1; op0 = op; wdata0 = data; end
        for (int n = 1; n <= 12 && done_cyc < 0; n++) begin
            @(negedge clk);
            if (pio_chipselect) begin
                cs_n++; cs_cyc = n; a = pio_address; wn = pio_write_n; wd = pio_writedata;
            end
            if (who ? done0 : done1) other_done = 1'b1;
            if (who ? done1 : done0) begin
                done_cyc = n; rd = rdata;
                if (who) req1 = 1'b0; else req0 = 1'b0;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        tail_bad = done0 | done1 | busy;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        #1;
        checks++;
        if ({pio_chipselect, pio_write_n, pio_address, pio_writedata} !== {1'b0, 1'b1, 3'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_bus: got cs=%b wn=%b addr=%0d wd=%h expected cs=0 wn=1 addr=0 wd=0",
                     pio_chipselect, pio_write_n, pio_address, pio_writedata);
        end
        checks++;
        if ({done0, done1, busy, rdata} !== {3'b000, 16'h0}) begin
            errors++;
            $display("FAIL reset_status: got done0=%b done1=%b busy=%b rdata=%h expected 0 0 0 0000",
                     done0, done1, busy, rdata);
        end
    endtask

    task automatic test_write();
        int cs_n, cs_cyc, done_cyc; logic [2:0] a; logic wn; logic [31:0] wd; logic [15:0] rd;
        bit od, tb;
        do_reset();
        drive_txn(1'b0, 2'b00, 16'h00A5, cs_n, cs_cyc, done_cyc, a, wn, wd, rd, od, tb);
        checks++;
        if (cs_cyc !== 1 || done_cyc !== 2 || cs_n !== 1) begin
            errors++;
            $display("FAIL write_latency: got cs_cycle=%0d done_cycle=%0d cs_count=%0d expected 1 2 1",
                     cs_cyc, done_cyc, cs_n);
        end
        checks++;
        if ({a, wn, wd} !== {3'd0, 1'b0, 32'h0000_00A5}) begin
            errors++;
            $display("FAIL write_bus: got addr=%0d wn=%b wd=%h expected addr=0 wn=0 wd=000000a5", a, wn, wd);
        end
        checks++;
        if (od || tb) begin
            errors++;
            $display("FAIL write_done_pulse: got other_done=%b tail=%b expected 0 0", od, tb);
        end
        checks++;
        if (pio_reg !== 16'h00A5) begin
            errors++;
            $display("FAIL write_pio: got %h expected 00a5", pio_reg);
        end
    endtask

    task automatic test_set_clear();
        int cs_n, cs_cyc, done_cyc; logic [2:0] a; logic wn; logic [31:0] wd; logic [15:0] rd;
        bit od, tb;
        drive_txn(1'b1, 2'b01, 16'h0F00, cs_n, cs_cyc, done_cyc, a, wn, wd, rd, od, tb);
        checks++;
        if ({a, wn, wd} !== {3'd4, 1'b0, 32'h0000_0F00} || done_cyc !== 2 || od) begin
            errors++;
            $display("FAIL set_bus: got addr=%0d wn=%b wd=%h done_cycle=%0d expected 4 0 00000f00 2",
                     a, wn, wd, done_cyc);
        end
        checks++;
        if (pio_reg !== 16'h0FA5) begin
            errors++;
            $display("FAIL set_pio: got %h expected 0fa5", pio_reg);
        end
        drive_txn(1'b1, 2'b10, 16'h0005, cs_n, cs_cyc, done_cyc, a, wn, wd, rd, od, tb);
        checks++;
        if ({a, wn, wd} !== {3'd5, 1'b0, 32'h0000_0005} || done_cyc !== 2 || od || tb) begin
            errors++;
            $display("FAIL clear_bus: got addr=%0d wn=%b wd=%h done_cycle=%0d expected 5 0 00000005 2",
                     a, wn, wd, done_cyc);
        end
        checks++;
        if (pio_reg !== 16'h0FA0) begin
            errors++;
            $display("FAIL clear_pio: got %h expected 0fa0", pio_reg);
        end
    endtask

    task automatic test_read();
        int cs_n, cs_cyc, done_cyc; logic [2:0] a; logic wn; logic [31:0] wd; logic [15:0] rd;
        bit od, tb;
        drive_txn(1'b0, 2'b11, 16'hFFFF, cs_n, cs_cyc, done_cyc, a, wn, wd, rd, od, tb);
        checks++;
        if (a !== 3'd0 || wn !== 1'b1 || done_cyc !== 2) begin
            errors++;
            $display("FAIL read_bus: got addr=%0d wn=%b done_cycle=%0d expected 0 1 2", a, wn, done_cyc);
        end
        checks++;
        if (rd !== 16'h0FA0 || pio_reg !== 16'h0FA0) begin
            errors++;
            $display("FAIL read_data: got rdata=%h pio=%h expected 0fa0 0fa0", rd, pio_reg);
        end
        repeat (3) @(negedge clk);
        drive_txn(1'b1, 2'b00, 16'h0001, cs_n, cs_cyc, done_cyc, a, wn, wd, rd, od, tb);
        checks++;
        if (rdata !== 16'h0FA0) begin
            errors++;
            $display("FAIL read_hold: got %h expected 0fa0", rdata);
        end
    endtask

    task automatic test_fairness();
        int k = 0; int cyc[4]; bit who_got[4]; bit overlap = 1'b0; bit last = 1'b1; bit exp_who;
        do_reset();
        req0 = 1'b1; op0 = 2'b00; wdata0 = 16'h1111;
        req1 = 1'b1; op1 = 2'b00; wdata1 = 16'h2222;
        for (int n = 1; n <= 40 && k < 4; n++) begin
            @(negedge clk);
            if (done0 && done1) overlap = 1'b1;
            if (pio_chipselect) begin
                who_got[k] = (pio_writedata[15:0] == 16'h2222); cyc[k] = n; k++;
            end
        end
        @(negedge clk);
        if (done0 && done1) overlap = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        checks++;
        if (k !== 4) begin
            errors++;
            $display("FAIL fair_count: got %0d bus cycles expected 4", k);
        end
        for (int i = 0; i < k; i++) begin
            exp_who = FIXED ? 1'b0 : ~last;
            last = exp_who;
            checks++;
            if (who_got[i] !== exp_who) begin
                errors++;
                $display("FAIL fair_order[%0d]: got requester %0d expected %0d", i, who_got[i], exp_who);
            end
            if (i > 0) begin
                checks++;
                if (cyc[i] - cyc[i-1] !== 3) begin
                    errors++;
                    $display("FAIL fair_spacing[%0d]: got %0d cycles expected 3", i, cyc[i] - cyc[i-1]);
                end
            end
        end
        checks++;
        if (overlap) begin
            errors++;
            $display("FAIL fair_overlap: got done0&done1 high together expected never");
        end
    endtask

    task automatic test_reset_mid();
        int cs_n, cs_cyc, done_cyc; logic [2:0] a; logic wn; logic [31:0] wd; logic [15:0] rd;
        bit od, tb; bit stray = 1'b0;
        do_reset();
        req0 = 1'b1; op0 = 2'b00; wdata0 = 16'h1234;
        @(negedge clk);
        checks++;
        if (pio_chipselect !== 1'b1) begin
            errors++;
            $display("FAIL mid_issue: got cs=%b expected 1", pio_chipselect);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({pio_chipselect, busy, done0, done1} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_abort: got cs=%b busy=%b done0=%b done1=%b expected 0 0 0 0",
                     pio_chipselect, busy, done0, done1);
        end
        req0 = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done0 || done1 || pio_chipselect) stray = 1'b1;
        end
        checks++;
        if (stray || pio_reg !== 16'h0) begin
            errors++;
            $display("FAIL mid_no_done: got stray=%b pio=%h expected 0 0000", stray, pio_reg);
        end
        drive_txn(1'b0, 2'b00, 16'h0042, cs_n, cs_cyc, done_cyc, a, wn, wd, rd, od, tb);
        checks++;
        if (done_cyc !== 2 || pio_reg !== 16'h0042) begin
            errors++;
            $display("FAIL mid_recover: got done_cycle=%0d pio=%h expected 2 0042", done_cyc, pio_reg);
        end
    endtask

    task automatic test_back_to_back();
        int cs_n = 0; int d_n = 0; int cs_at[2]; int d_at[2];
        do_reset();
        req0 = 1'b1; op0 = 2'b00; wdata0 = 16'h0011;
        cs_at[0] = -1; cs_at[1] = -1; d_at[0] = -1; d_at[1] = -1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (pio_chipselect) begin if (cs_n < 2) cs_at[cs_n] = n; cs_n++; end
            if (done0) begin if (d_n < 2) d_at[d_n] = n; d_n++; end
            if (n == 4) req0 = 1'b0;
        end
        checks++;
        if (cs_n !== 2 || cs_at[0] !== 1 || cs_at[1] !== 4) begin
            errors++;
            $display("FAIL b2b_bus: got count=%0d at %0d,%0d expected 2 at 1,4", cs_n, cs_at[0], cs_at[1]);
        end
        checks++;
        if (d_n !== 2 || d_at[0] !== 2 || d_at[1] !== 5) begin
            errors++;
            $display("FAIL b2b_done: got count=%0d at %0d,%0d expected 2 at 2,5", d_n, d_at[0], d_at[1]);
        end
    endtask

    // Random rounds: each round one or both requesters raise a request from idle.
    task automatic test_random();
        logic [15:0] pio_exp = '0;
        bit last = 1'b1;
        logic [1:0] r, op [2];
        logic [15:0] dat [2];
        logic [EW-1:0] cur;
        bit order [2]; int need, served; bit w;
        logic [2:0] ea;
        do_reset();
        exp_q.delete();
        cur = '0;
        for (int round = 0; round < 40; round++) begin
            r = 2'($urandom_range(1, 3));
            for (int j = 0; j < 2; j++) begin
                op[j]  = 2'($urandom_range(0, 3));
                dat[j] = 16'($urandom);
            end
            if (r == 2'b11) begin
                order[0] = FIXED ? 1'b0 : ~last; order[1] = ~order[0]; need = 2;
            end else begin
                order[0] = r[1]; order[1] = 1'b0; need = 1;
            end
            for (int j = 0; j < need; j++) begin
                w = order[j];
                last = w;
                case (op[w])
                    2'b01:   ea = 3'd4;
                    2'b10:   ea = 3'd5;
                    default: ea = 3'd0;
                endcase
                exp_q.push_back({w, ea, (op[w] == 2'b11), dat[w], pio_exp});
                case (op[w])
                    2'b00:   pio_exp = dat[w];
                    2'b01:   pio_exp = pio_exp | dat[w];
                    2'b10:   pio_exp = pio_exp & ~dat[w];
                    default: ;
                endcase
            end
            req0 = r[0]; op0 = op[0]; wdata0 = dat[0];
            req1 = r[1]; op1 = op[1]; wdata1 = dat[1];
            served = 0;
            for (int n = 0; n < 8 * need && served < need; n++) begin
                @(negedge clk);
                if (pio_chipselect) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rand_unexpected_cycle: got bus cycle addr=%0d expected none", pio_address);
                    end else begin
                        cur = exp_q.pop_front();
                        if ({pio_address, pio_write_n, pio_writedata} !== {cur[35:33], cur[32], 16'h0, cur[31:16]}) begin
                            errors++;
                            $display("FAIL rand_bus r%0d: got addr=%0d wn=%b wd=%h expected addr=%0d wn=%b wd=%h",
                                     round, pio_address, pio_write_n, pio_writedata, cur[35:33], cur[32], cur[31:16]);
                        end
                    end
                end
                if (done0 || done1) begin
                    checks++;
                    if ({done0, done1} !== (cur[36] ? 2'b01 : 2'b10)) begin
                        errors++;
                        $display("FAIL rand_done r%0d: got done0=%b done1=%b expected requester %0d",
                                 round, done0, done1, cur[36]);
                    end
                    if (cur[32]) begin
                        checks++;
                        if (rdata !== cur[15:0]) begin
                            errors++;
                            $display("FAIL rand_rdata r%0d: got %h expected %h", round, rdata, cur[15:0]);
                        end
                    end
                    if (done0) req0 = 1'b0;
                    if (done1) req1 = 1'b0;
                    served++;
                end
            end
            checks++;
            if (served !== need) begin
                errors++;
                $display("FAIL rand_timeout r%0d: got %0d completions expected %0d", round, served, need);
            end
            req0 = 1'b0; req1 = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (pio_reg !== pio_exp || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_final: got pio=%h pending=%0d expected pio=%h pending=0",
                     pio_reg, exp_q.size(), pio_exp);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_set_clear();
        test_read();
        test_fairness();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
